// File: rtl/tcs_pkg.sv
// Shared encodings for the TCS3200 channel scanner: filter pin codes, FSM states
// and the channel scan order.
package tcs_pkg;

  localparam logic [1:0] FLT_RED   = 2'b00;
  localparam logic [1:0] FLT_BLUE  = 2'b01;
  localparam logic [1:0] FLT_CLEAR = 2'b10;
  localparam logic [1:0] FLT_GREEN = 2'b11;

  localparam logic [1:0] SCALE_OFF = 2'b00;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_GATE   = 2'd2;
  localparam logic [1:0] ST_STORE  = 2'd3;

  // Scan order; the numeric value doubles as the shadow register index.
  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_BLUE  = 2'd1,
    CH_GREEN = 2'd2,
    CH_CLEAR = 2'd3
  } chan_e;

  function automatic logic [1:0] chan_filter(input chan_e ch);
    logic [1:0] code;
    case (ch)
      CH_RED:   code = FLT_RED;
      CH_BLUE:  code = FLT_BLUE;
      CH_GREEN: code = FLT_GREEN;
      default:  code = FLT_CLEAR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tcs_edge_sync.sv
// Two-flop synchronizer for the sensor OUT pin followed by a rising-edge detector.
// A pin edge sampled on one clock shows up as a counted edge two clocks later.
module tcs_edge_sync
  import tcs_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_in_i,
  output logic edge_pulse_o
);

  // [0],[1] synchronize; [2] holds the previous synchronized level for edge detect.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], async_in_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign edge_pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tcs_channel_scanner.sv
// TCS3200 front-end: steps the photodiode filter through RED, BLUE, GREEN, CLEAR and
// counts sensor edges in a fixed gate window per channel, publishing a full frame at once.
//
// state  | meaning
// IDLE   | sensor disabled, waiting for run
// SETTLE | filter just changed, edges ignored
// GATE   | counting synchronized rising edges
// STORE  | latch count into channel shadow; publish frame after CLEAR
module tcs_channel_scanner
  import tcs_pkg::*;
#(
  parameter int         GATE_CYCLES   = 1_000_000,
  parameter int         SETTLE_CYCLES = 10_000,
  parameter int         CNT_W         = 20,
  parameter logic [1:0] SCALE_SEL     = 2'b11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             sensor_freq_i,
  output logic [1:0]       scale_o,
  output logic [1:0]       filter_o,
  output logic             enf_o,
  output logic [CNT_W-1:0] red_cnt_o,
  output logic [CNT_W-1:0] blue_cnt_o,
  output logic [CNT_W-1:0] green_cnt_o,
  output logic [CNT_W-1:0] clear_cnt_o,
  output logic             frame_valid_o
);

  localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;

  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic edge_pulse;

  tcs_edge_sync u_edge_sync (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .async_in_i   (sensor_freq_i),
    .edge_pulse_o (edge_pulse)
  );

  logic [1:0]                 state_q,  state_d;
  chan_e                      ch_q,     ch_d;
  logic [TMR_W-1:0]           tmr_q,    tmr_d;
  logic [CNT_W-1:0]           cnt_q,    cnt_d;
  logic [3:0][CNT_W-1:0]      shd_q,    shd_d;
  logic [1:0]                 scale_q,  scale_d;
  logic [1:0]                 filter_q, filter_d;
  logic                       enf_q,    enf_d;
  logic [CNT_W-1:0]           red_q,    red_d;
  logic [CNT_W-1:0]           blue_q,   blue_d;
  logic [CNT_W-1:0]           green_q,  green_d;
  logic [CNT_W-1:0]           clear_q,  clear_d;
  logic                       fv_q,     fv_d;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    shd_d    = shd_q;
    scale_d  = scale_q;
    filter_d = filter_q;
    enf_d    = enf_q;
    red_d    = red_q;
    blue_d   = blue_q;
    green_d  = green_q;
    clear_d  = clear_q;
    fv_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        enf_d   = 1'b0;
        scale_d = SCALE_OFF;
        if (run_i) begin
          // Fresh shadows so an aborted frame can never leak into the next one.
          state_d  = ST_SETTLE;
          ch_d     = CH_RED;
          filter_d = FLT_RED;
          enf_d    = 1'b1;
          scale_d  = SCALE_SEL;
          tmr_d    = SETTLE_LOAD;
          shd_d    = '0;
        end
      end

      ST_SETTLE: begin
        if (tmr_q == '0) begin
          state_d = ST_GATE;
          tmr_d   = GATE_LOAD;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_GATE: begin
        if (edge_pulse && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (tmr_q == '0) begin
          state_d = ST_STORE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      ST_STORE: begin
        shd_d[ch_q] = cnt_q;
        if (ch_q == CH_CLEAR) begin
          red_d   = shd_q[CH_RED];
          blue_d  = shd_q[CH_BLUE];
          green_d = shd_q[CH_GREEN];
          clear_d = cnt_q;
          fv_d    = 1'b1;
        end
        if (run_i) begin
          state_d  = ST_SETTLE;
          ch_d     = chan_e'(ch_q + 2'd1);
          filter_d = chan_filter(chan_e'(ch_q + 2'd1));
          tmr_d    = SETTLE_LOAD;
        end else begin
          state_d  = ST_IDLE;
          filter_d = FLT_RED;
          enf_d    = 1'b0;
          scale_d  = SCALE_OFF;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ch_q     <= CH_RED;
      tmr_q    <= '0;
      cnt_q    <= '0;
      shd_q    <= '0;
      scale_q  <= SCALE_OFF;
      filter_q <= FLT_RED;
      enf_q    <= 1'b0;
      red_q    <= '0;
      blue_q   <= '0;
      green_q  <= '0;
      clear_q  <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      shd_q    <= shd_d;
      scale_q  <= scale_d;
      filter_q <= filter_d;
      enf_q    <= enf_d;
      red_q    <= red_d;
      blue_q   <= blue_d;
      green_q  <= green_d;
      clear_q  <= clear_d;
      fv_q     <= fv_d;
    end
  end

  assign scale_o       = scale_q;
  assign filter_o      = filter_q;
  assign enf_o         = enf_q;
  assign red_cnt_o     = red_q;
  assign blue_cnt_o    = blue_q;
  assign green_cnt_o   = green_q;
  assign clear_cnt_o   = clear_q;
  assign frame_valid_o = fv_q;

endmodule

// File: tb/tb_tcs_channel_scanner.sv
// Self-checking bench for tcs_channel_scanner: sensor waveforms are generated from a
// per-slot period table and the expected counts are derived from the frame timing.
module tb_tcs_channel_scanner;

  localparam int G     = 100;
  localparam int S     = 8;
  localparam int PER   = S + G + 1;
  localparam int FRAME = 4 * PER;
  localparam int CW    = 20;
  localparam int SW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int SMAX  = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          sensor;
  logic [1:0]    scale, filter;
  logic          enf;
  logic [CW-1:0] red_cnt, blue_cnt, green_cnt, clear_cnt;
  logic          frame_valid;

  logic          run_s;
  logic          sensor_s;
  logic [1:0]    s_scale, s_filter;
  logic          s_enf;
  logic [SW-1:0] s_red, s_blue, s_green, s_clear;
  logic          s_fv;

  int checks = 0;
  int errors = 0;

  int per_slot [0:31];
  bit settle_mode = 1'b0;
  int exp_r = 0, exp_b = 0, exp_g = 0, exp_c = 0;
  logic [1:0] flt_of [0:3];

  always #5 clk = ~clk;

  tcs_channel_scanner #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(CW), .SCALE_SEL(2'b11)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .sensor_freq_i(sensor),
    .scale_o(scale), .filter_o(filter), .enf_o(enf),
    .red_cnt_o(red_cnt), .blue_cnt_o(blue_cnt), .green_cnt_o(green_cnt), .clear_cnt_o(clear_cnt),
    .frame_valid_o(frame_valid)
  );

  tcs_channel_scanner #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(SW), .SCALE_SEL(2'b11)) dut_sat (
    .clk_i(clk), .rst_i(rst), .run_i(run_s), .sensor_freq_i(sensor_s),
    .scale_o(s_scale), .filter_o(s_filter), .enf_o(s_enf),
    .red_cnt_o(s_red), .blue_cnt_o(s_blue), .green_cnt_o(s_green), .clear_cnt_o(s_clear),
    .frame_valid_o(s_fv)
  );

  // Sensor level at cycle t (t = posedges since run was first sampled).
  function automatic bit wave(input int t);
    int slot, off, p;
    if (t < 0) return 1'b0;
    slot = t / PER;
    off  = t % PER;
    if (settle_mode) return (off == 2 || off == 3 || off == S - 2);
    p = per_slot[slot % 32];
    if (p == 0) return 1'b0;
    return (t % p) < (p / 2);
  endfunction

  // Pin rises at t are counted when t+1 falls in the slot's gate (2-flop sync latency).
  function automatic int model_cnt(input int slot, input int cmax);
    int lo, n;
    lo = slot * PER + S - 1;
    n  = 0;
    for (int t = lo; t < lo + G; t++)
      if (wave(t) && !wave(t - 1)) n++;
    return (n > cmax) ? cmax : n;
  endfunction

  task automatic run_frames(input int nframes);
    bit fv_exp;
    int base;
    for (int k = 0; k <= FRAME * nframes; k++) begin
      @(negedge clk);
      run    = 1'b1;
      sensor = wave(k);
      @(posedge clk);
      #1;
      fv_exp = (k > 0) && (k % FRAME == 0);
      if (fv_exp) begin
        base  = 4 * (k / FRAME - 1);
        exp_r = model_cnt(base,     CMAX);
        exp_b = model_cnt(base + 1, CMAX);
        exp_g = model_cnt(base + 2, CMAX);
        exp_c = model_cnt(base + 3, CMAX);
      end
      checks++;
      if (filter !== flt_of[(k / PER) % 4]) begin
        errors++;
        $display("FAIL filter k=%0d got %b want %b", k, filter, flt_of[(k / PER) % 4]);
      end
      checks++;
      if (enf !== 1'b1 || scale !== 2'b11) begin
        errors++;
        $display("FAIL pins_running k=%0d got enf=%b scale=%b want enf=1 scale=11", k, enf, scale);
      end
      checks++;
      if (frame_valid !== fv_exp) begin
        errors++;
        $display("FAIL frame_valid k=%0d got %b want %b", k, frame_valid, fv_exp);
      end
      checks++;
      if (red_cnt !== CW'(exp_r) || blue_cnt !== CW'(exp_b) ||
          green_cnt !== CW'(exp_g) || clear_cnt !== CW'(exp_c)) begin
        errors++;
        $display("FAIL counts k=%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k,
                 red_cnt, blue_cnt, green_cnt, clear_cnt, exp_r, exp_b, exp_g, exp_c);
      end
    end
  endtask

  task automatic stop_run();
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      run    = 1'b0;
      sensor = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (frame_valid !== 1'b0 || red_cnt !== CW'(exp_r) || blue_cnt !== CW'(exp_b) ||
          green_cnt !== CW'(exp_g) || clear_cnt !== CW'(exp_c)) begin
        errors++;
        $display("FAIL stop_hold k=%0d got fv=%b %0d/%0d/%0d/%0d want fv=0 %0d/%0d/%0d/%0d", k,
                 frame_valid, red_cnt, blue_cnt, green_cnt, clear_cnt, exp_r, exp_b, exp_g, exp_c);
      end
    end
    checks++;
    if (enf !== 1'b0 || scale !== 2'b00) begin
      errors++;
      $display("FAIL stop_idle got enf=%b scale=%b want enf=0 scale=00", enf, scale);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; sensor = 1'b0; run_s = 1'b0; sensor_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (scale !== 2'b00 || filter !== 2'b00 || enf !== 1'b0 || frame_valid !== 1'b0 ||
          red_cnt !== '0 || blue_cnt !== '0 || green_cnt !== '0 || clear_cnt !== '0) begin
        errors++;
        $display("FAIL reset cyc=%0d got scale=%b filter=%b enf=%b fv=%b cnt=%0d/%0d/%0d/%0d want all 0",
                 i, scale, filter, enf, frame_valid, red_cnt, blue_cnt, green_cnt, clear_cnt);
      end
    end
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_uniform();
    settle_mode = 1'b0;
    for (int i = 0; i < 32; i++) per_slot[i] = 10;
    run_frames(1);
    checks++;
    if (red_cnt !== 20'd10 || blue_cnt !== 20'd10 || green_cnt !== 20'd10 || clear_cnt !== 20'd10) begin
      errors++;
      $display("FAIL uniform got %0d/%0d/%0d/%0d want 10 each", red_cnt, blue_cnt, green_cnt, clear_cnt);
    end
    stop_run();
  endtask

  task automatic test_per_filter();
    settle_mode = 1'b0;
    for (int i = 0; i < 32; i += 4) begin
      per_slot[i] = 4; per_slot[i+1] = 20; per_slot[i+2] = 50; per_slot[i+3] = 0;
    end
    run_frames(1);
    checks++;
    if (red_cnt !== 20'd25 || blue_cnt !== 20'd5 || green_cnt !== 20'd2 || clear_cnt !== 20'd0) begin
      errors++;
      $display("FAIL per_filter got %0d/%0d/%0d/%0d want 25/5/2/0", red_cnt, blue_cnt, green_cnt, clear_cnt);
    end
    stop_run();
  endtask

  task automatic test_back_to_back();
    settle_mode = 1'b0;
    for (int i = 0; i < 32; i++)
      per_slot[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 40));
    run_frames(3);
    stop_run();
  endtask

  task automatic test_settle_blanking();
    settle_mode = 1'b1;
    run_frames(1);
    checks++;
    if (red_cnt !== '0 || blue_cnt !== '0 || green_cnt !== '0 || clear_cnt !== '0) begin
      errors++;
      $display("FAIL settle_blank got %0d/%0d/%0d/%0d want 0 each", red_cnt, blue_cnt, green_cnt, clear_cnt);
    end
    settle_mode = 1'b0;
    stop_run();
  endtask

  task automatic test_abort();
    int drop_t, idle_t;
    drop_t = PER + S + 50;
    idle_t = 2 * PER;
    for (int i = 0; i < 32; i++) per_slot[i] = int'($urandom_range(2, 30));
    for (int k = 0; k <= 300; k++) begin
      @(negedge clk);
      run    = (k < drop_t);
      sensor = wave(k);
      @(posedge clk);
      #1;
      checks++;
      if (frame_valid !== 1'b0 || red_cnt !== CW'(exp_r) || blue_cnt !== CW'(exp_b) ||
          green_cnt !== CW'(exp_g) || clear_cnt !== CW'(exp_c)) begin
        errors++;
        $display("FAIL abort_hold k=%0d got fv=%b %0d/%0d/%0d/%0d want fv=0 %0d/%0d/%0d/%0d", k,
                 frame_valid, red_cnt, blue_cnt, green_cnt, clear_cnt, exp_r, exp_b, exp_g, exp_c);
      end
      checks++;
      if (k < idle_t) begin
        if (enf !== 1'b1 || filter !== flt_of[k / PER]) begin
          errors++;
          $display("FAIL abort_active k=%0d got enf=%b filter=%b want enf=1 filter=%b",
                   k, enf, filter, flt_of[k / PER]);
        end
      end else if (enf !== 1'b0 || scale !== 2'b00) begin
        errors++;
        $display("FAIL abort_idle k=%0d got enf=%b scale=%b want enf=0 scale=00", k, enf, scale);
      end
    end
    run_frames(1);
    stop_run();
  endtask

  task automatic test_rst_mid();
    int rst_t;
    rst_t = 2 * PER + S + 30;
    for (int i = 0; i < 32; i++) per_slot[i] = int'($urandom_range(2, 30));
    for (int k = 0; k <= rst_t; k++) begin
      @(negedge clk);
      run    = 1'b1;
      rst    = (k == rst_t);
      sensor = wave(k);
      @(posedge clk);
      #1;
      checks++;
      if (k < rst_t) begin
        if (filter !== flt_of[k / PER] || enf !== 1'b1) begin
          errors++;
          $display("FAIL rst_pre k=%0d got filter=%b enf=%b want filter=%b enf=1",
                   k, filter, enf, flt_of[k / PER]);
        end
      end else if (scale !== 2'b00 || filter !== 2'b00 || enf !== 1'b0 || frame_valid !== 1'b0 ||
                   red_cnt !== '0 || blue_cnt !== '0 || green_cnt !== '0 || clear_cnt !== '0) begin
        errors++;
        $display("FAIL rst_mid got scale=%b filter=%b enf=%b fv=%b cnt=%0d/%0d/%0d/%0d want all 0",
                 scale, filter, enf, frame_valid, red_cnt, blue_cnt, green_cnt, clear_cnt);
      end
    end
    exp_r = 0; exp_b = 0; exp_g = 0; exp_c = 0;
    @(negedge clk);
    rst = 1'b0; run = 1'b0; sensor = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (enf !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_after got enf=%b fv=%b want 0/0", enf, frame_valid);
    end
    for (int i = 0; i < 32; i++) per_slot[i] = int'($urandom_range(2, 40));
    run_frames(1);
    stop_run();
  endtask

  task automatic test_saturation();
    int want;
    want = (G / 2 > SMAX) ? SMAX : G / 2;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      run_s    = 1'b1;
      sensor_s = (k % 2 == 0);
      @(posedge clk);
      #1;
      checks++;
      if (s_fv !== (k == FRAME)) begin
        errors++;
        $display("FAIL sat_fv k=%0d got %b want %b", k, s_fv, (k == FRAME));
      end
    end
    checks++;
    if (s_red !== SW'(want) || s_blue !== SW'(want) || s_green !== SW'(want) || s_clear !== SW'(want)) begin
      errors++;
      $display("FAIL saturation got %0d/%0d/%0d/%0d want %0d each", s_red, s_blue, s_green, s_clear, want);
    end
    @(negedge clk);
    run_s = 1'b0; sensor_s = 1'b0;
  endtask

  initial begin
    flt_of[0] = 2'b00; flt_of[1] = 2'b01; flt_of[2] = 2'b11; flt_of[3] = 2'b10;
    for (int i = 0; i < 32; i++) per_slot[i] = 0;
    test_reset();
    test_uniform();
    test_per_filter();
    test_back_to_back();
    test_settle_blanking();
    test_abort();
    test_rst_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
